psum_accumulator: RTL and testbench
===================================

PSUM_ACCUMULATOR -- requirements
Module: psum_accumulator

Interface
REQ-001 The block SHALL have parameter ARRAY_SIZE, default 4, giving the number of independent lanes.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, giving the Q16.16 operand width.
REQ-003 The block SHALL have parameter GUARD_BITS, default 5, giving the accumulator headroom bits.
REQ-004 The block SHALL derive PSUM_WIDTH = 2*DATA_WIDTH (Q32.32 product) and ACC_WIDTH = 2*DATA_WIDTH+GUARD_BITS (69, Q37.32); these are not overridable.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock.
REQ-006 The block SHALL have port rst, input, 1 bit, reset that is synchronous to clk and active-high.
REQ-007 The block SHALL have port in_valid, input, 1 bit, upstream beat valid.
REQ-008 The block SHALL have port in_ready, output, 1 bit, block accepts a beat.
REQ-009 The block SHALL have port in_psum, input, ARRAY_SIZE*PSUM_WIDTH bits, signed Q32.32 per lane, with lane i at [i*PSUM_WIDTH +: PSUM_WIDTH].
REQ-010 The block SHALL have port in_first, input, 1 bit, marking the first term of a reduction.
REQ-011 The block SHALL have port in_last, input, 1 bit, marking the final term of a reduction.
REQ-012 The block SHALL have port out_valid, output, 1 bit, accumulated result valid.
REQ-013 The block SHALL have port out_ready, input, 1 bit, downstream quantize path accepts the result.
REQ-014 The block SHALL have port out_acc, output, ARRAY_SIZE*ACC_WIDTH bits, signed Q37.32 per lane, using the same lane packing as in_psum.
REQ-015 The block SHALL have port term_ovf, output, 1 bit, asserted when the reduction exceeded 2^GUARD_BITS terms.

Function
REQ-016 The block SHALL implement the FSM states IDLE, ACCUM and HOLD.
REQ-017 The block SHALL drive in_ready = 1 in IDLE and ACCUM and in_ready = 0 in HOLD.
REQ-018 The block SHALL accept a beat only when in_valid && in_ready are both high in the same cycle.
REQ-019 On an accepted beat in IDLE, or any accepted beat with in_first=1, the block SHALL set acc[i] = sign_extend(in_psum[i]) to ACC_WIDTH and set the term count to 1.
REQ-020 On any other accepted beat, the block SHALL set acc[i] = acc[i] + sign_extend(in_psum[i]) and add 1 to the term count; the count is 7 bits and saturates at 127.
REQ-021 An accepted beat with in_first=1 in ACCUM SHALL discard the partial sum with no error indication.
REQ-022 An accepted beat with in_last=0 SHALL move the FSM to ACCUM; an accepted beat with in_last=1 SHALL move it to HOLD, including when in_first=1 (a single-term reduction).
REQ-023 The block SHALL assert out_valid exactly when in HOLD; latency SHALL be 1 cycle from the in_last beat being accepted to out_valid=1 with the final sum.
REQ-024 While out_valid && !out_ready, out_acc and term_ovf SHALL remain stable.
REQ-025 When out_valid && out_ready, the FSM SHALL return to IDLE in the next cycle, and in_ready SHALL be 1 in that next cycle.
REQ-026 The block SHALL drive term_ovf = (term count > 2^GUARD_BITS), registered alongside the sum; term_ovf is meaningful only while out_valid is high.
REQ-027 Addition SHALL be two's complement modulo 2^ACC_WIDTH, with no saturation inside the block; saturation and rounding are done downstream in quantize.
REQ-028 All lanes SHALL share the handshake and the FSM; lanes SHALL NOT stall independently.

Reset
REQ-029 When rst=1 at a clk edge, the block SHALL set state=IDLE, out_valid=0, term_ovf=0, term count=0 and acc=0 for all lanes, overriding any simultaneous beat.
REQ-030 Reset SHALL take effect in ACCUM or HOLD alike; a held result is dropped, and in_ready=1 in the cycle after rst is released.

Structure
REQ-031 The constants DATA_WIDTH, GUARD_BITS, PSUM_WIDTH and ACC_WIDTH, plus the state encoding type, SHALL reside in the shared package tpu_pkg.
REQ-032 The per-lane sign-extend/add/register datapath SHALL be the sub-module psum_acc_lane, instantiated ARRAY_SIZE times by a generate loop.
REQ-033 The FSM and term counter SHALL be instantiated once in psum_accumulator.

Verification
REQ-034 Bench SHALL cover a basic sum: 3 beats of lane0 psum 64'h0000_0001_0000_0000 (1.0), first on beat 1 and last on beat 3, each held for one cycle -> out_acc lane0 = 69'h0_0000_0003_0000_0000 with out_valid 1 cycle after beat 3 and term_ovf=0.
REQ-035 Bench SHALL cover a negative sum: psum 64'hFFFF_FFFF_0000_0000 (-1.0) as a single beat with first=last=1 -> out_acc = 69'h1F_FFFF_FFFF_0000_0000.
REQ-036 Bench SHALL cover headroom: 32 beats of 64'h7FFF_FFFF_FFFF_FFFF -> out_acc = 69'h0F_FFFF_FFFF_FFFF_FFE0 with term_ovf=0; the same stimulus with 33 beats -> term_ovf=1.
REQ-037 Bench SHALL cover backpressure: out_ready=0 for 5 cycles during HOLD -> out_acc stable and in_ready=0 throughout; on out_ready=1, in_ready=1 the next cycle.
REQ-038 Bench SHALL cover restart and reset: in_first mid-reduction -> result equals only the new terms; rst pulsed in ACCUM -> out_valid stays 0, and the next reduction sums only post-reset beats.
REQ-039 Bench SHALL cover lane independence: ARRAY_SIZE=4 with distinct per-lane values (1.0, -2.0, 0.5, 0) over 2 beats -> each lane equals its own sum of 2 beats.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared constants and FSM encoding for the TPU partial-sum path.
// Widths are Q16.16 operands, Q32.32 products, Q37.32 accumulators.
package tpu_pkg;
   localparam int DATA_WIDTH = 32;
   localparam int GUARD_BITS = 5;
   localparam int PSUM_WIDTH = 2 * DATA_WIDTH;
   localparam int ACC_WIDTH  = 2 * DATA_WIDTH + GUARD_BITS;
   localparam int CNT_WIDTH  = 7;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } acc_state_e;
endpackage

// File: rtl/psum_acc_lane.sv
// One lane: sign-extend a Q32.32 psum and load or add it into a Q37.32 register.
// Result visible one cycle after load_i; the lane has no handshake of its own.
module psum_acc_lane import tpu_pkg::*; #(
   parameter int PSUM_WIDTH = tpu_pkg::PSUM_WIDTH,
   parameter int ACC_WIDTH  = tpu_pkg::ACC_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  load_i,
   input  logic                  restart_i,
   input  logic [PSUM_WIDTH-1:0] psum_i,
   output logic [ACC_WIDTH-1:0]  acc_o
);
   logic [ACC_WIDTH-1:0] acc_q, acc_d, psum_ext;

   assign psum_ext = {{(ACC_WIDTH - PSUM_WIDTH){psum_i[PSUM_WIDTH-1]}}, psum_i};

   // Wraps modulo 2^ACC_WIDTH; saturation belongs to the quantize stage.
   always_comb begin
      acc_d = acc_q;
      if (load_i) begin
         acc_d = restart_i ? psum_ext : acc_q + psum_ext;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc_o = acc_q;
endmodule

// File: rtl/psum_accumulator.sv
// Multi-lane partial-sum reducer: result valid 1 cycle after the last beat is accepted.
// in_ready drops while the result is held; out_acc/term_ovf stay stable until out_ready.
module psum_accumulator import tpu_pkg::*; #(
   parameter int ARRAY_SIZE = 4,
   parameter int DATA_WIDTH = tpu_pkg::DATA_WIDTH,
   parameter int GUARD_BITS = tpu_pkg::GUARD_BITS
) (
   input  logic                                          clk,
   input  logic                                          rst,
   input  logic                                          in_valid,
   output logic                                          in_ready,
   input  logic [ARRAY_SIZE*(2*DATA_WIDTH)-1:0]          in_psum,
   input  logic                                          in_first,
   input  logic                                          in_last,
   output logic                                          out_valid,
   input  logic                                          out_ready,
   output logic [ARRAY_SIZE*(2*DATA_WIDTH+GUARD_BITS)-1:0] out_acc,
   output logic                                          term_ovf
);
   localparam int PSUM_WIDTH = 2 * DATA_WIDTH;
   localparam int ACC_WIDTH  = 2 * DATA_WIDTH + GUARD_BITS;
   localparam int OVF_LIMIT  = 1 << GUARD_BITS;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   acc_state_e           state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 ovf_q, ovf_d;
   logic                 accept;
   logic                 restart;

   assign in_ready  = (state_q != HOLD);
   assign accept    = in_valid && in_ready;
   // A beat arriving in IDLE always opens a new reduction, whatever in_first says.
   assign restart   = (state_q == IDLE) || in_first;
   assign out_valid = (state_q == HOLD);
   assign term_ovf  = ovf_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE, ACCUM: begin
            if (accept) begin
               state_d = in_last ? HOLD : ACCUM;
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (accept) begin
         if (restart) begin
            cnt_d = CNT_WIDTH'(1);
         end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
         end
         ovf_d = (int'(cnt_d) > OVF_LIMIT);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

   for (genvar g = 0; g < ARRAY_SIZE; g++) begin : g_lane
      psum_acc_lane #(
         .PSUM_WIDTH (PSUM_WIDTH),
         .ACC_WIDTH  (ACC_WIDTH)
      ) u_lane (
         .clk_i     (clk),
         .rst_i     (rst),
         .load_i    (accept),
         .restart_i (restart),
         .psum_i    (in_psum[g*PSUM_WIDTH +: PSUM_WIDTH]),
         .acc_o     (out_acc[g*ACC_WIDTH +: ACC_WIDTH])
      );
   end
endmodule

// File: tb/tb_psum_accumulator.sv
// Randomized and directed bench for psum_accumulator against a sum-of-terms reference model.
module tb_psum_accumulator;
   localparam int AS = 4;
   localparam int PW = 64;
   localparam int AW = 69;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid, in_ready, in_first, in_last;
   logic              out_valid, out_ready, term_ovf;
   logic [AS*PW-1:0]  in_psum;
   logic [AS*AW-1:0]  out_acc;

   int checks = 0;
   int errors = 0;

   logic [PW-1:0] stim [AS];
   logic [AW-1:0] m_acc [AS];
   int            m_cnt;
   bit            m_idle;

   psum_accumulator #(.ARRAY_SIZE(AS), .DATA_WIDTH(32), .GUARD_BITS(5)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_psum(in_psum), .in_first(in_first), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
      .term_ovf(term_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [AW-1:0] sext(input logic [PW-1:0] p);
      return {{(AW-PW){p[PW-1]}}, p};
   endfunction

   task automatic scramble_inputs();
      for (int i = 0; i < AS; i++) in_psum[i*PW +: PW] = {$urandom, $urandom};
   endtask

   // Called at a negedge; presents stim[] for one cycle and updates the reference sums.
   task automatic beat(input bit first, input bit last);
      chk("in_ready_beat", in_ready, 1);
      in_valid = 1'b1;
      in_first = first;
      in_last  = last;
      for (int i = 0; i < AS; i++) begin
         in_psum[i*PW +: PW] = stim[i];
         if (m_idle || first) m_acc[i] = sext(stim[i]);
         else                 m_acc[i] = m_acc[i] + sext(stim[i]);
      end
      if (m_idle || first) m_cnt = 1;
      else if (m_cnt < 127) m_cnt++;
      m_idle = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      in_first = $urandom_range(0, 1);
      in_last  = $urandom_range(0, 1);
      scramble_inputs();
   endtask

   task automatic expect_result(input string tag);
      chk({tag, "_vld"}, out_valid, 1);
      for (int i = 0; i < AS; i++) chk({tag, "_acc"}, out_acc[i*AW +: AW], m_acc[i]);
      chk({tag, "_ovf"}, term_ovf, (m_cnt > 32));
   endtask

   // Holds the result for 'hold' cycles while offering beats that must be ignored.
   task automatic drain(input int hold);
      out_ready = 1'b0;
      repeat (hold) begin
         in_valid = 1'b1;
         in_first = $urandom_range(0, 1);
         scramble_inputs();
         @(negedge clk);
         expect_result("hold");
         chk("hold_rdy", in_ready, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("post_vld", out_valid, 0);
      chk("post_rdy", in_ready, 1);
      m_idle = 1'b1;
   endtask

   task automatic set_lane0(input logic [PW-1:0] v);
      stim[0] = v;
      for (int i = 1; i < AS; i++) stim[i] = '0;
   endtask

   initial begin
      logic [AS*AW-1:0] lane_acc;
      rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
      out_ready = 1'b0; in_psum = '0;
      m_idle = 1'b1; m_cnt = 0;
      for (int i = 0; i < AS; i++) m_acc[i] = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_vld", out_valid, 0);
      chk("rst_ovf", term_ovf, 0);
      chk("rst_rdy", in_ready, 1);
      chk("rst_acc", out_acc, 0);

      // Basic: three beats of 1.0 on lane 0.
      set_lane0(64'h0000_0001_0000_0000);
      beat(1, 0); beat(0, 0); beat(0, 1);
      expect_result("basic");
      lane_acc = out_acc;
      chk("basic_const", lane_acc[AW-1:0], 69'h0_0000_0003_0000_0000);
      drain(0);

      // Single-term negative reduction.
      set_lane0(64'hFFFF_FFFF_0000_0000);
      beat(1, 1);
      expect_result("neg");
      lane_acc = out_acc;
      chk("neg_const", lane_acc[AW-1:0], 69'h1F_FFFF_FFFF_0000_0000);
      drain(1);

      // Headroom: 32 terms fit, 33 flag overflow.
      set_lane0(64'h7FFF_FFFF_FFFF_FFFF);
      for (int b = 0; b < 32; b++) beat(b == 0, b == 31);
      expect_result("head32");
      lane_acc = out_acc;
      chk("head32_const", lane_acc[AW-1:0], 69'h0F_FFFF_FFFF_FFFF_FFE0);
      chk("head32_ovf", term_ovf, 0);
      drain(0);
      for (int b = 0; b < 33; b++) beat(b == 0, b == 32);
      expect_result("head33");
      chk("head33_ovf", term_ovf, 1);

      // Backpressure for 5 cycles.
      drain(5);

      // Restart mid-reduction: only 2.0 + 3.0 survive.
      set_lane0(64'h0000_0005_0000_0000); beat(1, 0);
      set_lane0(64'h0000_0007_0000_0000); beat(0, 0);
      set_lane0(64'h0000_0002_0000_0000); beat(1, 0);
      set_lane0(64'h0000_0003_0000_0000); beat(0, 1);
      expect_result("restart");
      lane_acc = out_acc;
      chk("restart_const", lane_acc[AW-1:0], 69'h0_0000_0005_0000_0000);
      drain(2);

      // Reset in ACCUM, with a simultaneous beat that must be overridden.
      set_lane0(64'h0000_0009_0000_0000);
      beat(1, 0); beat(0, 0);
      rst = 1'b1; in_valid = 1'b1; in_last = 1'b1;
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0;
      chk("rstmid_vld", out_valid, 0);
      chk("rstmid_rdy", in_ready, 1);
      chk("rstmid_acc", out_acc, 0);
      m_idle = 1'b1;
      @(negedge clk);
      chk("rstmid_vld2", out_valid, 0);
      set_lane0(64'h0000_0001_0000_0000);
      beat(0, 0); beat(0, 1);
      expect_result("postrst");
      lane_acc = out_acc;
      chk("postrst_const", lane_acc[AW-1:0], 69'h0_0000_0002_0000_0000);
      drain(0);

      // Lane independence: 1.0, -2.0, 0.5, 0 over two beats.
      stim[0] = 64'h0000_0001_0000_0000;
      stim[1] = 64'hFFFF_FFFE_0000_0000;
      stim[2] = 64'h0000_0000_8000_0000;
      stim[3] = 64'h0;
      beat(1, 0); beat(0, 1);
      expect_result("lanes");
      lane_acc = out_acc;
      chk("lane0", lane_acc[0*AW +: AW], 69'h0_0000_0002_0000_0000);
      chk("lane1", lane_acc[1*AW +: AW], 69'h1F_FFFF_FFFC_0000_0000);
      chk("lane2", lane_acc[2*AW +: AW], 69'h0_0000_0001_0000_0000);
      chk("lane3", lane_acc[3*AW +: AW], 69'h0);
      drain(1);

      // Random reductions with gaps, mid-stream restarts and backpressure.
      for (int r = 0; r < 30; r++) begin
         int len;
         len = $urandom_range(1, 40);
         for (int b = 0; b < len; b++) begin
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            for (int i = 0; i < AS; i++) stim[i] = {$urandom, $urandom};
            beat((b == 0) || ($urandom_range(0, 9) == 0), b == len - 1);
         end
         expect_result("rand");
         drain($urandom_range(0, 3));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule
